// File: rtl/local_clock_adj.sv
// local_clock_adj: picosecond time-of-day counter with fractional rate trim,
// absolute set, offset steps, per-channel timestamp capture and wrap pulse.
// Optional feature macro: LOCAL_CLOCK_SLEW_EN (slewed offset steps). When it
// is undefined, an accepted step is applied whole in the acceptance cycle.
module local_clock_adj #(
  parameter int unsigned     CLOCK_PERIOD_PS = 8000,
  parameter int unsigned     TIMESTAMP_WIDTH = 59,
  parameter int unsigned     FRAC_WIDTH      = 16,
  parameter int unsigned     RATE_WIDTH      = 24,
  parameter int unsigned     MAX_SLEW_PS     = 1000,
  parameter int unsigned     NUM_CAPTURE     = 4,
  parameter longint unsigned RESET_VALUE     = 64'd1000000000000
) (
  input  logic                                   clk,
  input  logic                                   reset,
  output logic [TIMESTAMP_WIDTH-1:0]             local_clock,
  input  logic                                   set_valid,
  input  logic [TIMESTAMP_WIDTH-1:0]             set_value,
  input  logic                                   step_valid,
  output logic                                   step_ready,
  input  logic [TIMESTAMP_WIDTH-1:0]             step_value,
  input  logic                                   rate_valid,
  input  logic [RATE_WIDTH-1:0]                  rate_value,
  input  logic [NUM_CAPTURE-1:0]                 cap_req,
  output logic [NUM_CAPTURE-1:0]                 cap_valid,
  output logic [NUM_CAPTURE*TIMESTAMP_WIDTH-1:0] cap_ts,
  output logic                                   wrap
);

  localparam int unsigned TW = TIMESTAMP_WIDTH;
  localparam int unsigned FW = FRAC_WIDTH;
  localparam int unsigned AW = TW + FW;
  // Two guard bits: bit AW is the forward carry, bit AW+1 the sign of a
  // backward move, so a negative step never masquerades as a wrap.
  localparam int unsigned SW = AW + 2;

  localparam logic [TW-1:0] RESET_TS = TW'(RESET_VALUE);
  localparam logic [SW-1:0] NOM_INC  = SW'(CLOCK_PERIOD_PS) << FW;

  logic [AW-1:0]                acc;
  logic signed [RATE_WIDTH-1:0] rate_reg;
  logic signed [TW-1:0]         applied;
  logic [SW-1:0]                delta;
  logic [SW-1:0]                sum;
  logic                         step_fire;

  assign local_clock = acc[AW-1:FW];
  assign step_fire   = step_valid & step_ready;

`ifdef LOCAL_CLOCK_SLEW_EN
  typedef enum logic {IDLE, SLEW} state_t;

  localparam logic signed [TW-1:0] SLEW_MAX = TW'(MAX_SLEW_PS);
  localparam logic signed [TW-1:0] SLEW_MIN = -SLEW_MAX;

  state_t               state;
  logic signed [TW-1:0] residual;

  assign step_ready = (state == IDLE);

  // Clamp the outstanding offset to the per-cycle slew limit.
  always_comb begin
    applied = '0;
    if (state == SLEW) begin
      if (residual > SLEW_MAX)      applied = SLEW_MAX;
      else if (residual < SLEW_MIN) applied = SLEW_MIN;
      else                          applied = residual;
    end
  end

  // Step FSM: set and reset both discard any outstanding residual.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      residual <= '0;
    end else if (set_valid) begin
      state    <= IDLE;
      residual <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (step_fire && (step_value != '0)) begin
            residual <= step_value;
            state    <= SLEW;
          end
        end
        SLEW: begin
          residual <= residual - applied;
          if (residual == applied) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
`else
  assign step_ready = 1'b1;

  // Without slewing, an accepted step lands in full in its own cycle.
  always_comb begin
    applied = '0;
    if (step_fire) applied = step_value;
  end
`endif

  // Signed per-cycle advance: nominal period + rate trim + step offset.
  always_comb begin
    delta = NOM_INC
          + {{(SW-RATE_WIDTH){rate_reg[RATE_WIDTH-1]}}, rate_reg}
          + ({{(SW-TW){applied[TW-1]}}, applied} << FW);
    sum   = {2'b00, acc} + delta;
  end

  // Time accumulator, rate register, wrap pulse and capture channels.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc       <= {RESET_TS, {FW{1'b0}}};
      rate_reg  <= '0;
      wrap      <= 1'b0;
      cap_valid <= '0;
      cap_ts    <= '0;
    end else begin
      if (rate_valid) rate_reg <= rate_value;
      if (set_valid) begin
        acc  <= {set_value, {FW{1'b0}}};
        wrap <= 1'b0;
      end else begin
        acc  <= sum[AW-1:0];
        wrap <= (sum[SW-1:AW] == 2'b01);
      end
      cap_valid <= cap_req;
      for (int unsigned i = 0; i < NUM_CAPTURE; i++) begin
        if (cap_req[i]) cap_ts[i*TW +: TW] <= local_clock;
      end
    end
  end

endmodule

// File: tb/tb_local_clock_adj.sv
// tb_local_clock_adj: directed, table-driven bench for local_clock_adj.
// Expectations follow the build: LOCAL_CLOCK_SLEW_EN selects slewed steps.
module tb_local_clock_adj;

  localparam int W  = 59;
  localparam int NC = 4;
  localparam longint RV = 64'd1000000000000;

  logic          clk = 1'b0;
  logic          reset;
  logic [W-1:0]  local_clock;
  logic          set_valid;
  logic [W-1:0]  set_value;
  logic          step_valid;
  logic          step_ready;
  logic [W-1:0]  step_value;
  logic          rate_valid;
  logic [23:0]   rate_value;
  logic [NC-1:0] cap_req;
  logic [NC-1:0] cap_valid;
  logic [NC*W-1:0] cap_ts;
  logic          wrap;

  int checks = 0;
  int errors = 0;

  local_clock_adj #(
    .CLOCK_PERIOD_PS(8000),
    .TIMESTAMP_WIDTH(W),
    .FRAC_WIDTH(16),
    .RATE_WIDTH(24),
    .MAX_SLEW_PS(1000),
    .NUM_CAPTURE(NC),
    .RESET_VALUE(64'd1000000000000)
  ) dut (
    .clk(clk), .reset(reset), .local_clock(local_clock),
    .set_valid(set_valid), .set_value(set_value),
    .step_valid(step_valid), .step_ready(step_ready), .step_value(step_value),
    .rate_valid(rate_valid), .rate_value(rate_value),
    .cap_req(cap_req), .cap_valid(cap_valid), .cap_ts(cap_ts), .wrap(wrap)
  );

  always #4 clk = ~clk;

  typedef struct {
    logic         sv;
    logic [W-1:0] setv;
    logic         rv;
    logic [23:0]  ratev;
    logic [W-1:0] exp_lc;
    logic         exp_wrap;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_set(input logic [W-1:0] v);
    set_valid = 1'b1; set_value = v;
    cyc();
    set_valid = 1'b0;
    chk("set_load", 64'(local_clock), 64'(v));
  endtask

  // Step of sv from base; d0..d3 are cumulative offsets after each of the
  // four edges starting with the acceptance edge, rdy the step_ready after each.
  task automatic step_test(input string nm, input logic [W-1:0] sv, input longint base,
                           input longint d0, input longint d1, input longint d2,
                           input longint d3, input logic [3:0] rdy);
    longint d[4];
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
    do_set(W'(base));
    step_valid = 1'b1; step_value = sv;
    for (int k = 0; k < 4; k++) begin
      cyc();
      step_valid = 1'b0;
      chk({nm, "_lc"}, 64'(local_clock), 64'(W'(base + d[k])));
      chk({nm, "_rdy"}, 64'(step_ready), 64'(rdy[k]));
    end
  endtask

  initial begin
    logic [W-1:0] topv;
    logic [W-1:0] s0;
    logic [W-1:0] neg2500;
    longint v;

    reset = 1'b1; set_valid = 1'b0; set_value = '0; step_valid = 1'b0;
    step_value = '0; rate_valid = 1'b0; rate_value = '0; cap_req = '0;

    // Reset held for 3 cycles, inputs active but ignored.
    for (int k = 0; k < 3; k++) begin
      rate_valid = 1'b1; rate_value = 24'd32768;
      cyc();
      chk("reset_lc", 64'(local_clock), 64'(RV));
    end
    rate_valid = 1'b0; rate_value = '0;
    chk("reset_ready", 64'(step_ready), 64'd1);
    chk("reset_capv", 64'(cap_valid), 64'd0);
    chk("reset_capts", 64'(cap_ts[W-1:0]), 64'd0);
    chk("reset_wrap", 64'(wrap), 64'd0);
    reset = 1'b0;

    for (int k = 1; k <= 5; k++) begin
      cyc();
      chk("run_lc", 64'(local_clock), 64'(RV + 8000 * k));
      chk("run_wrap", 64'(wrap), 64'd0);
    end

    // Table: wrap, positive/negative half-ps trim, trim removal.
    topv = '1;
    s0   = topv - W'(15999);
    vecs[0]  = '{1'b1, s0, 1'b0, 24'd0, s0, 1'b0};
    vecs[1]  = '{1'b0, '0, 1'b0, 24'd0, s0 + W'(8000), 1'b0};
    vecs[2]  = '{1'b0, '0, 1'b0, 24'd0, W'(0), 1'b1};
    vecs[3]  = '{1'b0, '0, 1'b0, 24'd0, W'(8000), 1'b0};
    vecs[4]  = '{1'b1, W'(5000000), 1'b1, 24'd32768, W'(5000000), 1'b0};
    vecs[5]  = '{1'b0, '0, 1'b0, 24'd0, W'(5008000), 1'b0};
    vecs[6]  = '{1'b0, '0, 1'b0, 24'd0, W'(5016001), 1'b0};
    vecs[7]  = '{1'b0, '0, 1'b0, 24'd0, W'(5024001), 1'b0};
    vecs[8]  = '{1'b0, '0, 1'b0, 24'd0, W'(5032002), 1'b0};
    vecs[9]  = '{1'b1, W'(6000000), 1'b1, 24'hFF8000, W'(6000000), 1'b0};
    vecs[10] = '{1'b0, '0, 1'b0, 24'd0, W'(6007999), 1'b0};
    vecs[11] = '{1'b0, '0, 1'b0, 24'd0, W'(6015999), 1'b0};
    vecs[12] = '{1'b0, '0, 1'b0, 24'd0, W'(6023998), 1'b0};
    vecs[13] = '{1'b0, '0, 1'b0, 24'd0, W'(6031998), 1'b0};
    vecs[14] = '{1'b1, W'(7000000), 1'b1, 24'd0, W'(7000000), 1'b0};
    vecs[15] = '{1'b0, '0, 1'b0, 24'd0, W'(7008000), 1'b0};

    for (int i = 0; i < 16; i++) begin
      set_valid = vecs[i].sv; set_value = vecs[i].setv;
      rate_valid = vecs[i].rv; rate_value = vecs[i].ratev;
      cyc();
      chk($sformatf("vec%0d_lc", i), 64'(local_clock), 64'(vecs[i].exp_lc));
      chk($sformatf("vec%0d_wrap", i), 64'(wrap), 64'(vecs[i].exp_wrap));
      chk($sformatf("vec%0d_rdy", i), 64'(step_ready), 64'd1);
    end
    set_valid = 1'b0; rate_valid = 1'b0;

    // Offset steps.
    neg2500 = W'(0) - W'(2500);
`ifdef LOCAL_CLOCK_SLEW_EN
    step_test("step_pos", W'(2500), 10000000, 8000, 17000, 26000, 34500, 4'b1000);
    step_test("step_neg", neg2500, 11000000, 8000, 15000, 22000, 29500, 4'b1000);
`else
    step_test("step_pos", W'(2500), 10000000, 10500, 18500, 26500, 34500, 4'b1111);
    step_test("step_neg", neg2500, 11000000, 5500, 13500, 21500, 29500, 4'b1111);
`endif
    step_test("step_zero", W'(0), 12000000, 8000, 16000, 24000, 32000, 4'b1111);

    // Set mid-slew together with a new step: set wins, step dropped.
    do_set(W'(30000000));
    step_valid = 1'b1; step_value = W'(5000);
    cyc();
    step_valid = 1'b0;
    cyc();
`ifdef LOCAL_CLOCK_SLEW_EN
    chk("midslew_lc", 64'(local_clock), 64'(30017000));
    chk("midslew_rdy", 64'(step_ready), 64'd0);
`else
    chk("midslew_lc", 64'(local_clock), 64'(30021000));
    chk("midslew_rdy", 64'(step_ready), 64'd1);
`endif
    set_valid = 1'b1; set_value = W'(40000000);
    step_valid = 1'b1; step_value = W'(3000);
    cyc();
    set_valid = 1'b0; step_valid = 1'b0;
    chk("setwin_lc", 64'(local_clock), 64'(40000000));
    chk("setwin_rdy", 64'(step_ready), 64'd1);
    for (int k = 1; k <= 3; k++) begin
      cyc();
      chk("setwin_after_lc", 64'(local_clock), 64'(40000000 + 8000 * k));
      chk("setwin_after_rdy", 64'(step_ready), 64'd1);
    end

    // Reset in the middle of a step discards the outstanding offset.
    do_set(W'(50000000));
    step_valid = 1'b1; step_value = W'(5000);
    cyc();
    step_valid = 1'b0;
    cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("rst_slew_lc", 64'(local_clock), 64'(RV));
    chk("rst_slew_rdy", 64'(step_ready), 64'd1);
    for (int k = 1; k <= 3; k++) begin
      cyc();
      chk("rst_slew_after_lc", 64'(local_clock), 64'(RV + 8000 * k));
    end

    // Capture: channel 2 first, then channels 0, 1, 3 at a later time.
    do_set(W'(20000000));
    cap_req = 4'b0100;
    cyc();
    cap_req = 4'b0000;
    chk("cap1_valid", 64'(cap_valid), 64'b0100);
    chk("cap1_ch2", 64'(cap_ts[2*W +: W]), 64'(20000000));
    cyc();
    chk("cap1_clear", 64'(cap_valid), 64'b0000);
    cap_req = 4'b1011;
    cyc();
    cap_req = 4'b0000;
    v = 20016000;
    chk("cap2_valid", 64'(cap_valid), 64'b1011);
    chk("cap2_ch0", 64'(cap_ts[0*W +: W]), 64'(v));
    chk("cap2_ch1", 64'(cap_ts[1*W +: W]), 64'(v));
    chk("cap2_ch2", 64'(cap_ts[2*W +: W]), 64'(20000000));
    chk("cap2_ch3", 64'(cap_ts[3*W +: W]), 64'(v));
    cyc();
    chk("cap2_clear", 64'(cap_valid), 64'b0000);
    chk("cap2_hold", 64'(cap_ts[3*W +: W]), 64'(v));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
